// File: rtl/rsa_codec.sv
// RSA encrypt/decrypt engine: constant-time left-to-right square-and-multiply
// over a bit-serial interleaved modular multiplier, with run-time loadable keys.
module rsa_codec #(
    parameter int K      = 12,
    parameter int EW     = 12,
    parameter int N_INIT = 3551,
    parameter int E_INIT = 5,
    parameter int D_INIT = 1373
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          mode,
    input  logic [K-1:0]  data_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [K-1:0]  data_out,
    output logic          err,
    output logic          busy,
    input  logic          key_we,
    input  logic [1:0]    key_sel,
    input  logic [K-1:0]  key_wdata
);
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam int IW = (EW > 1) ? $clog2(EW) : 1;

    typedef enum logic [1:0] {IDLE, SQR, MUL, DONE} state_t;

    state_t          state;
    logic [K-1:0]    n_reg;
    logic [EW-1:0]   e_reg;
    logic [EW-1:0]   d_reg;
    logic [K-1:0]    m_reg;
    logic [EW-1:0]   exp_reg;
    logic [K-1:0]    acc;
    logic [K-1:0]    r;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   idx;
    logic            fin;

    logic [K:0]      n_ext;
    logic [K:0]      r_dbl;
    logic [K-1:0]    r_red;
    logic [K:0]      r_add;
    logic [K-1:0]    r_next;
    logic [K-1:0]    mul_b;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // One multiplier step: results are always < n, so the reduced values fit in K bits.
    always_comb begin
        n_ext  = {1'b0, n_reg};
        mul_b  = (state == MUL) ? m_reg : acc;
        r_dbl  = {r, 1'b0};
        r_red  = (r_dbl >= n_ext) ? (r_dbl[K-1:0] - n_reg) : r_dbl[K-1:0];
        r_add  = acc[cnt] ? ({1'b0, r_red} + {1'b0, mul_b}) : {1'b0, r_red};
        r_next = (r_add >= n_ext) ? (r_add[K-1:0] - n_reg) : r_add[K-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            n_reg     <= K'(N_INIT);
            e_reg     <= EW'(E_INIT);
            d_reg     <= EW'(D_INIT);
            m_reg     <= '0;
            exp_reg   <= '0;
            acc       <= '0;
            r         <= '0;
            cnt       <= '0;
            idx       <= '0;
            fin       <= 1'b0;
            out_valid <= 1'b0;
            data_out  <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        m_reg   <= data_in;
                        exp_reg <= mode ? d_reg : e_reg;
                        idx     <= IW'(EW - 1);
                        acc     <= K'(1);
                        r       <= '0;
                        cnt     <= CW'(K - 1);
                        fin     <= 1'b0;
                        state   <= SQR;
                    end else if (key_we) begin
                        case (key_sel)
                            2'd0:    n_reg <= key_wdata;
                            2'd1:    e_reg <= key_wdata[EW-1:0];
                            2'd2:    d_reg <= key_wdata[EW-1:0];
                            default: ;
                        endcase
                    end
                end
                SQR: begin
                    // Out-of-range input is rejected on the first cycle after accept.
                    if (m_reg >= n_reg) begin
                        data_out  <= '0;
                        err       <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (cnt == '0) begin
                        acc   <= r_next;
                        r     <= '0;
                        cnt   <= CW'(K - 1);
                        state <= MUL;
                    end else begin
                        r   <= r_next;
                        cnt <= cnt - 1'b1;
                    end
                end
                MUL: begin
                    if (fin) begin
                        data_out  <= acc;
                        err       <= 1'b0;
                        out_valid <= 1'b1;
                        fin       <= 1'b0;
                        state     <= DONE;
                    end else if (cnt == '0) begin
                        // The product is always computed; the exponent bit only picks whether to keep it.
                        if (exp_reg[idx]) begin
                            acc <= r_next;
                        end
                        r   <= '0;
                        cnt <= CW'(K - 1);
                        if (idx == '0) begin
                            fin <= 1'b1;
                        end else begin
                            idx   <= idx - 1'b1;
                            state <= SQR;
                        end
                    end else begin
                        r   <= r_next;
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rsa_codec.sv
// Scoreboard bench for rsa_codec: directed transactions push expected results,
// an independent monitor pops and compares whenever a result is presented.
module tb_rsa_codec;
    localparam int K       = 12;
    localparam int EW      = 12;
    localparam int LAT     = 2 * K * EW + 1;
    localparam int BUSY_LO = 2 * K * EW + 2;

    typedef struct {
        logic [K-1:0] data;
        logic         err;
        int           acc_cyc;
        int           lat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          mode = 1'b0;
    logic [K-1:0]  data_in = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [K-1:0]  data_out;
    logic          err;
    logic          busy;
    logic          key_we = 1'b0;
    logic [1:0]    key_sel = 2'd3;
    logic [K-1:0]  key_wdata = '0;

    exp_t sb[$];
    int   compared = 0;
    int   mismatched = 0;
    int   cyc = 0;
    int   first_cyc = 0;
    logic seen = 1'b0;

    rsa_codec #(.K(K), .EW(EW), .N_INIT(3551), .E_INIT(5), .D_INIT(1373)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .err(err), .busy(busy), .key_we(key_we),
        .key_sel(key_sel), .key_wdata(key_wdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Present one message, wait (bounded) for acceptance, then record the expected result.
    task automatic applyStimulus(input logic md, input logic [K-1:0] din,
                                 input logic [K-1:0] exp_data, input logic exp_err,
                                 input int exp_lat, input logic keep, output int low);
        exp_t e;
        low      = 0;
        in_valid = 1'b1;
        mode     = md;
        data_in  = din;
        if (!in_ready) begin
            for (int t = 0; t < 2000; t++) begin
                @(negedge clk);
                if (in_ready) break;
                low++;
            end
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", int'(in_ready), 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        e.data    = exp_data;
        e.err     = exp_err;
        e.acc_cyc = cyc;
        e.lat     = exp_lat;
        sb.push_back(e);
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic keyWrite(input logic [1:0] sel, input logic [K-1:0] val);
        key_we    = 1'b1;
        key_sel   = sel;
        key_wdata = val;
        @(posedge clk);
        #1;
        key_we  = 1'b0;
        key_sel = 2'd3;
    endtask

    task automatic drain();
        int done = 0;
        for (int t = 0; t < 1000; t++) begin
            @(negedge clk);
            if (sb.size() == 0 && in_ready) begin
                done = 1;
                break;
            end
        end
        checkOutput("drain_timeout", done, 1);
    endtask

    // Monitor: compares every presented result against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                checkOutput("out_valid_with_empty_queue", int'(out_valid), 0);
            end else begin
                if (!seen) begin
                    seen = 1'b1;
                    first_cyc = cyc;
                end
                if (out_ready) begin
                    e = sb.pop_front();
                    checkOutput("data_out", int'(data_out), int'(e.data));
                    checkOutput("err", int'(err), int'(e.err));
                    checkOutput("latency", first_cyc - e.acc_cyc, e.lat);
                    seen = 1'b0;
                end else begin
                    checkOutput("held_data_out", int'(data_out), int'(sb[0].data));
                    checkOutput("held_err", int'(err), int'(sb[0].err));
                end
            end
        end
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        mismatched++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int low;
        int got;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_in_ready", int'(in_ready), 1);
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_data_out", int'(data_out), 0);
        checkOutput("reset_err", int'(err), 0);
        checkOutput("reset_busy", int'(busy), 0);

        applyStimulus(1'b0, 12'd100, 12'd492, 1'b0, LAT, 1'b0, low);
        applyStimulus(1'b1, 12'd492, 12'd100, 1'b0, LAT, 1'b0, low);
        applyStimulus(1'b0, 12'd2, 12'd32, 1'b0, LAT, 1'b0, low);
        drain();

        // Stall the consumer: result, err and handshake state must hold.
        @(posedge clk);
        #1 out_ready = 1'b0;
        applyStimulus(1'b1, 12'd32, 12'd2, 1'b0, LAT, 1'b0, low);
        got = 0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1;
                break;
            end
        end
        checkOutput("hold_out_valid_timeout", got, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("hold_in_ready", int'(in_ready), 0);
            checkOutput("hold_out_valid", int'(out_valid), 1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain();

        applyStimulus(1'b0, 12'd3551, 12'd0, 1'b1, 1, 1'b0, low);
        applyStimulus(1'b0, 12'd4095, 12'd0, 1'b1, 1, 1'b0, low);
        applyStimulus(1'b0, 12'd100, 12'd492, 1'b0, LAT, 1'b0, low);
        drain();

        keyWrite(2'd0, 12'd3233);
        keyWrite(2'd1, 12'd17);
        keyWrite(2'd2, 12'd2753);
        keyWrite(2'd3, 12'd7);
        applyStimulus(1'b0, 12'd65, 12'd2790, 1'b0, LAT, 1'b0, low);
        keyWrite(2'd1, 12'd3);
        keyWrite(2'd0, 12'd4000);
        applyStimulus(1'b1, 12'd2790, 12'd65, 1'b0, LAT, 1'b0, low);
        drain();
        key_we    = 1'b1;
        key_sel   = 2'd1;
        key_wdata = 12'd3;
        applyStimulus(1'b0, 12'd65, 12'd2790, 1'b0, LAT, 1'b0, low);
        key_we  = 1'b0;
        key_sel = 2'd3;
        applyStimulus(1'b0, 12'd65, 12'd2790, 1'b0, LAT, 1'b0, low);
        drain();

        keyWrite(2'd1, 12'd0);
        applyStimulus(1'b0, 12'd1234, 12'd1, 1'b0, LAT, 1'b0, low);
        drain();

        // Abort an operation 100 cycles in; keys must come back to their reset values.
        applyStimulus(1'b0, 12'd1234, 12'd1, 1'b0, LAT, 1'b0, low);
        repeat (99) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        seen = 1'b0;
        @(negedge clk);
        checkOutput("abort_out_valid", int'(out_valid), 0);
        checkOutput("abort_in_ready", int'(in_ready), 1);
        checkOutput("abort_busy", int'(busy), 0);
        applyStimulus(1'b0, 12'd100, 12'd492, 1'b0, LAT, 1'b0, low);
        applyStimulus(1'b1, 12'd492, 12'd100, 1'b0, LAT, 1'b0, low);
        drain();

        applyStimulus(1'b0, 12'd2, 12'd32, 1'b0, LAT, 1'b1, low);
        applyStimulus(1'b1, 12'd32, 12'd2, 1'b0, LAT, 1'b1, low);
        checkOutput("b2b_busy_cycles_1", low, BUSY_LO);
        applyStimulus(1'b0, 12'd100, 12'd492, 1'b0, LAT, 1'b0, low);
        checkOutput("b2b_busy_cycles_2", low, BUSY_LO);
        drain();

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
